regfile_write_arbiter: RTL and testbench

Write-port controller for the 16×16-bit register file. It shares the regfile's single write path (`ALUBus` plus the one-hot `regEnable`) between two writeback requesters, the ALU and the memory-load path, using round-robin arbitration. It also runs a 16-cycle clear sequence that zeroes every register. It sits between the execute/memory stages and `regfile`, and its outputs drive `regfile.ALUBus` and `regfile.regEnable` directly.

---
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the 16x16 register file: round-robin sharing of the
// single write path between ALU and load writeback, plus a 16-cycle clear walk.
module regfile_write_arbiter #(
  parameter int          WIDTH        = 16,
  parameter logic [15:0] PROTECT_MASK = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_req,
  input  logic [3:0]       alu_reg,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_gnt,
  input  logic             mem_req,
  input  logic [3:0]       mem_reg,
  input  logic [WIDTH-1:0] mem_data,
  output logic             mem_gnt,
  input  logic             clear_req,
  output logic             busy,
  output logic [WIDTH-1:0] ALUBus,
  output logic [15:0]      regEnable
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_idx, w_idx_nxt;
  logic             r_last, w_last_nxt;
  logic             r_busy;
  logic [WIDTH-1:0] r_bus, w_bus_nxt;
  logic [15:0]      r_en, w_en_nxt;
  logic             w_alu_win, w_mem_win, w_arb_ok;

  // r_last: 0 = ALU won most recently, 1 = MEM; the other side wins a tie.
  always_comb begin
    w_alu_win = alu_req && (!mem_req || r_last);
    w_mem_win = mem_req && (!alu_req || !r_last);
    w_arb_ok  = (r_state == ARB) && !clear_req && !reset;
    alu_gnt   = w_arb_ok && w_alu_win;
    mem_gnt   = w_arb_ok && w_mem_win;
  end

  // The entry edge already issues r0, so r_idx holds the next index to issue;
  // it wraps to 0 after r15, and that marks the final CLEAR cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_bus_nxt   = r_bus;
    w_en_nxt    = '0;
    case (r_state)
      ARB: begin
        if (clear_req) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = 4'd1;
          w_bus_nxt   = '0;
          w_en_nxt    = 16'h0001;
        end else if (w_alu_win) begin
          w_bus_nxt  = alu_data;
          w_en_nxt   = (16'h0001 << alu_reg) & ~PROTECT_MASK;
          w_last_nxt = 1'b0;
        end else if (w_mem_win) begin
          w_bus_nxt  = mem_data;
          w_en_nxt   = (16'h0001 << mem_reg) & ~PROTECT_MASK;
          w_last_nxt = 1'b1;
        end
      end
      CLEAR: begin
        if (r_idx == 4'd0) begin
          w_state_nxt = ARB;
        end else begin
          w_bus_nxt = '0;
          w_en_nxt  = 16'h0001 << r_idx;
          w_idx_nxt = r_idx + 4'd1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARB;
      r_idx   <= 4'd0;
      r_last  <= 1'b1;
      r_busy  <= 1'b0;
      r_bus   <= '0;
      r_en    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= (w_state_nxt == CLEAR);
      r_bus   <= w_bus_nxt;
      r_en    <= w_en_nxt;
    end
  end

  assign busy      = r_busy;
  assign ALUBus    = r_bus;
  assign regEnable = r_en;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic, checked
// every cycle against a cycle-level behavioural model and a shadow register file.
module tb_regfile_write_arbiter;
  localparam int          WIDTH = 16;
  localparam logic [15:0] MASK  = 16'h0001;

  logic             clk = 1'b0;
  logic             reset;
  logic             alu_req, mem_req, clear_req;
  logic [3:0]       alu_reg, mem_reg;
  logic [WIDTH-1:0] alu_data, mem_data;
  logic             alu_gnt, mem_gnt, busy;
  logic [WIDTH-1:0] ALUBus;
  logic [15:0]      regEnable;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.WIDTH(WIDTH), .PROTECT_MASK(MASK)) dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_reg(alu_reg), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_reg(mem_reg), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .clear_req(clear_req), .busy(busy), .ALUBus(ALUBus), .regEnable(regEnable)
  );

  // Behavioural model: clear_left counts remaining CLEAR cycles (0 = arbitrating)
  int          n_chk = 0, n_pass = 0;
  int          m_last, m_clear_left;
  logic [15:0] m_en, m_bus;
  logic        m_busy, m_ga, m_gm;
  logic [15:0] m_rf [16];
  logic [15:0] d_rf [16];

  function automatic void model_reset();
    m_last = 1; m_clear_left = 0; m_en = '0; m_bus = '0; m_busy = 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: inputs already driven (just after negedge); compare, then advance.
  task automatic cyc();
    logic [15:0] en_s, bus_s;
    #1;
    if (reset) model_reset();
    m_ga = 1'b0; m_gm = 1'b0;
    if (!reset && m_clear_left == 0 && !clear_req) begin
      if (alu_req && (!mem_req || m_last == 1)) m_ga = 1'b1;
      else if (mem_req) m_gm = 1'b1;
    end
    check("alu_gnt", alu_gnt, m_ga);
    check("mem_gnt", mem_gnt, m_gm);
    check("regEnable", regEnable, m_en);
    check("ALUBus", ALUBus, m_bus);
    check("busy", busy, m_busy);
    en_s = regEnable; bus_s = ALUBus;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      if (en_s[i]) d_rf[i] = bus_s;
      if (m_en[i]) m_rf[i] = m_bus;
    end
    if (reset) model_reset();
    else if (m_clear_left > 0) begin
      if (m_clear_left > 1) begin m_en = 16'h0001 << (17 - m_clear_left); m_bus = '0; end
      else begin m_en = '0; m_busy = 1'b0; end
      m_clear_left--;
    end else if (clear_req) begin
      m_clear_left = 16; m_en = 16'h0001; m_bus = '0; m_busy = 1'b1;
    end else if (m_ga) begin
      m_bus = alu_data; m_en = (16'h0001 << alu_reg) & ~MASK; m_last = 0;
    end else if (m_gm) begin
      m_bus = mem_data; m_en = (16'h0001 << mem_reg) & ~MASK; m_last = 1;
    end else m_en = '0;
    @(negedge clk);
  endtask

  task automatic idle();
    alu_req = 0; mem_req = 0; clear_req = 0;
  endtask

  initial begin
    logic [15:0] exp_w, saved;
    reset = 1; idle();
    alu_reg = 0; mem_reg = 0; alu_data = 0; mem_data = 0;
    model_reset();
    for (int i = 0; i < 16; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
    @(negedge clk);
    cyc(); cyc();
    reset = 0; cyc();

    // Reset asserted mid-cycle with both requesters active
    alu_req = 1; alu_reg = 4'd2; alu_data = 16'h0A0A;
    mem_req = 1; mem_reg = 4'd4; mem_data = 16'h0B0B;
    cyc();
    reset = 1; #1;
    check("rst_regEnable", regEnable, 16'h0000);
    check("rst_ALUBus", ALUBus, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_grants", {alu_gnt, mem_gnt}, 2'b00);
    cyc();
    reset = 0; #1;
    check("first_tie_alu", {alu_gnt, mem_gnt}, 2'b10);
    cyc(); idle(); cyc(); cyc();

    // Single ALU write r5 = BEEF
    alu_req = 1; alu_reg = 4'd5; alu_data = 16'hBEEF; #1;
    check("single_gnt", alu_gnt, 1'b1);
    cyc(); idle(); #1;
    check("single_en", regEnable, 16'h0020);
    check("single_bus", ALUBus, 16'hBEEF);
    cyc(); #1;
    check("single_en_pulse", regEnable, 16'h0000);
    cyc();
    check("single_r5", d_rf[5], 16'hBEEF);

    // MEM write so the next tie goes to the ALU, then continuous contention on r3
    mem_req = 1; mem_reg = 4'd9; mem_data = 16'h5A5A; cyc(); idle(); cyc();
    alu_req = 1; alu_reg = 4'd3; alu_data = 16'h1111;
    mem_req = 1; mem_reg = 4'd3; mem_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("contend_alt", {alu_gnt, mem_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
    end
    idle(); cyc(); cyc();
    check("contend_r3", d_rf[3], 16'h2222);

    // Back-to-back writes ri = i
    for (int i = 0; i < 16; i++) begin
      alu_req = 1; alu_reg = 4'(i); alu_data = 16'(i); #1;
      check("b2b_gnt", alu_gnt, 1'b1);
      if (i > 0) begin
        exp_w = (16'h0001 << (i - 1)) & ~MASK;
        check("b2b_en", regEnable, exp_w);
      end
      cyc();
    end
    idle(); cyc(); cyc();
    for (int i = 1; i < 16; i++) check("b2b_rf", d_rf[i], 16'(i));

    // Protected register r0
    saved = d_rf[0];
    alu_req = 1; alu_reg = 4'd0; alu_data = 16'h00FF; #1;
    check("prot_gnt", alu_gnt, 1'b1);
    cyc(); idle(); #1;
    check("prot_en", regEnable, 16'h0000);
    cyc(); cyc();
    check("prot_r0", d_rf[0], saved);

    // Clear with the ALU waiting on r7
    alu_req = 1; alu_reg = 4'd7; alu_data = 16'h1234; clear_req = 1; #1;
    check("clr_start_gnt", alu_gnt, 1'b0);
    cyc(); clear_req = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_w = 16'h0001 << k;
      check("clr_busy", busy, 1'b1);
      check("clr_walk", regEnable, exp_w);
      check("clr_gnt_blocked", alu_gnt, 1'b0);
      cyc();
    end
    for (int i = 0; i < 16; i++) check("clr_zero", d_rf[i], 16'h0000);
    #1;
    check("clr_done_busy", busy, 1'b0);
    check("clr_resume_gnt", alu_gnt, 1'b1);
    cyc(); idle(); cyc(); cyc();
    check("clr_r7", d_rf[7], 16'h1234);

    // Clear aborted by reset at idx 6
    for (int i = 1; i <= 8; i++) begin
      alu_req = 1; alu_reg = 4'(i); alu_data = 16'h00A0 + 16'(i); cyc();
    end
    idle(); clear_req = 1; cyc(); clear_req = 0;
    for (int k = 0; k < 6; k++) cyc();
    reset = 1; #1;
    check("abort_en", regEnable, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_bus", ALUBus, 16'h0000);
    cyc(); reset = 0; cyc(); cyc();
    for (int i = 1; i <= 5; i++) check("abort_cleared", d_rf[i], 16'h0000);
    check("abort_r6_kept", d_rf[6], 16'h00A6);

    // Random traffic honouring the hold-until-granted rule
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      clear_req = ($urandom_range(0, 59) == 0);
      if (!alu_req || m_ga) begin
        alu_req = ($urandom_range(0, 2) != 0);
        alu_reg = 4'($urandom_range(0, 15));
        alu_data = 16'($urandom);
      end
      if (!mem_req || m_gm) begin
        mem_req = ($urandom_range(0, 2) != 0);
        mem_reg = ($urandom_range(0, 3) == 0) ? alu_reg : 4'($urandom_range(0, 15));
        mem_data = 16'($urandom);
      end
      if (reset) begin m_ga = 1'b0; m_gm = 1'b0; end
      cyc();
    end
    reset = 0; idle(); cyc(); cyc();
    for (int i = 0; i < 16; i++) check("final_rf", d_rf[i], m_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
